branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Execute-side counterpart of the fetch-stage gshare/BTB predictor. It carries the
//  fetch prediction metadata through F->D->E pipeline registers and compares it against
//  the resolved branch or jump outcome in EX. It drives the redirect and predictor/BTB
//  update interface back into the IF stage, generates the wrong-path squash, and keeps
//  branch accuracy counters.
// PARAMETERS
//  XLEN       32  address/data width
//  PHT_IDX_W  8   gshare PHT index width (log2 of 256 entries)
//  CNT_W      32  performance counter width
// PORTS
//  clk              in   1          clock, all state on rising edge
//  rst              in   1          synchronous, active-high reset
//  stall            in   1          pipeline hold; freezes D and E metadata regs
//  F_valid          in   1          IF holds a real instruction this cycle
//  F_PC             in   XLEN       fetch PC
//  F_pred_taken     in   1          gshare direction prediction
//  F_pht_idx        in   PHT_IDX_W  PHT index used for prediction
//  F_btb_hit        in   1          BTB hit at fetch
//  F_btb_target     in   XLEN       BTB target at fetch
//  E_is_cond        in   1          EX instruction is a conditional branch
//  E_is_jump        in   1          EX instruction is JAL/JALR
//  E_cond_taken     in   1          branch comparator result
//  E_jb_target      in   XLEN       computed branch/jump target
//  redirect_valid   out  1          fetch must load redirect_pc
//  redirect_pc      out  XLEN       correct next PC
//  ex_update_en     out  1          one-shot predictor update strobe
//  ex_actual_taken  out  1          resolved direction (jumps = 1)
//  ex_pc            out  XLEN       PC of resolving instruction
//  ex_actual_target out  XLEN       resolved target
//  pht_idx_ex       out  PHT_IDX_W  PHT index carried from fetch
//  squash           out  1          kill younger instructions in IF/ID (= redirect_valid)
//  br_total         out  CNT_W      resolved control-flow instructions
//  br_mispred       out  CNT_W      resolved instructions that redirected
// BEHAVIOUR
//  - Reset: all D/E regs, valid bits, done flag and counters go to 0. All outputs are 0
//    in the cycle after reset is sampled.
//  - Pipeline:
//    - !stall: D <= {F_valid & !squash, F_*}; E <= {D_valid & !squash, D_*}.
//    - stall & !squash: D and E hold.
//    - squash: D_valid <= 0, independent of stall.
//  - Resolution in E (combinational from E regs and E_* inputs; zero latency):
//    - res = E_valid & (E_is_cond | E_is_jump) & !E_done.
//    - taken = E_is_jump | E_cond_taken.
//    - act_next = taken ? E_jb_target : E_pc + 4.
//    - pred_next = (E_pred_taken & E_btb_hit) ? E_btb_target : E_pc + 4.
//    - redirect_valid = res & (act_next != pred_next); redirect_pc = act_next.
//    - ex_update_en = res; ex_actual_taken = taken; ex_actual_target = E_jb_target.
//    - ex_pc = E_pc; pht_idx_ex = E_pht_idx.
//    - When redirect_valid = 0, redirect_pc and the ex_* data outputs are don't-care but
//      driven from the E regs.
//  - E_done flag (one-shot):
//    - Set when res & stall, so a stalled branch updates and redirects exactly once.
//    - Cleared whenever E loads new contents (!stall).
//  - Non-control instructions in E: no update, no redirect. A bubble (E_valid = 0)
//    produces nothing even if E_is_cond/E_is_jump are asserted.
//  - Counters: br_total += res; br_mispred += redirect_valid. Both update on the same
//    edge, wrap modulo 2^CNT_W, and never change while res = 0.
//  - PC + 4 wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
//  - Reset mid-operation: in-flight metadata is discarded, no strobe is emitted in the
//    reset cycle, and the first post-reset resolution sees E_valid = 0.
// TESTING
//  1. Reset: F_valid = 1, F_PC = 0x100, rst held 2 cycles -> all outputs 0, counters 0.
//  2. Correct taken prediction: F_PC = 0x40, pred_taken = 1, btb_hit = 1,
//     btb_target = 0x80; two cycles later E_is_cond = 1, cond_taken = 1,
//     jb_target = 0x80 -> ex_update_en = 1, redirect_valid = 0, br_total = 1,
//     br_mispred = 0.
//  3. Mispredict not-taken: PC = 0x40, pred_taken = 0, E_cond_taken = 1,
//     jb_target = 0x200 -> redirect_valid = 1, redirect_pc = 0x200,
//     pht_idx_ex = fetch idx; next cycle D_valid = 0.
//  4. Predicted taken, actually not taken: PC = 0x3C, btb_target = 0x10,
//     cond_taken = 0 -> redirect_pc = 0x40.
//  5. Stall for 3 cycles with a mispredicting branch in E -> ex_update_en and
//     redirect_valid high in the first cycle only; br_total increments exactly once.
//  6. JAL at 0xFFFF_FFFC with btb_hit = 0, jb_target = 0x8 -> ex_actual_taken = 1,
//     redirect_pc = 0x8, br_mispred increments.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in EX against the prediction carried from fetch; drives
// the fetch redirect, the predictor update strobe, the wrong-path squash and accuracy counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int PHT_IDX_W = 8,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 F_valid,
  input  logic [XLEN-1:0]      F_PC,
  input  logic                 F_pred_taken,
  input  logic [PHT_IDX_W-1:0] F_pht_idx,
  input  logic                 F_btb_hit,
  input  logic [XLEN-1:0]      F_btb_target,
  input  logic                 E_is_cond,
  input  logic                 E_is_jump,
  input  logic                 E_cond_taken,
  input  logic [XLEN-1:0]      E_jb_target,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 ex_update_en,
  output logic                 ex_actual_taken,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_actual_target,
  output logic [PHT_IDX_W-1:0] pht_idx_ex,
  output logic                 squash,
  output logic [CNT_W-1:0]     br_total,
  output logic [CNT_W-1:0]     br_mispred
);

  logic                 d_valid_reg, d_pred_taken_reg, d_btb_hit_reg;
  logic [XLEN-1:0]      d_pc_reg, d_btb_target_reg;
  logic [PHT_IDX_W-1:0] d_pht_idx_reg;
  logic                 e_valid_reg, e_pred_taken_reg, e_btb_hit_reg, e_done_reg;
  logic [XLEN-1:0]      e_pc_reg, e_btb_target_reg;
  logic [PHT_IDX_W-1:0] e_pht_idx_reg;
  logic [CNT_W-1:0]     br_total_reg, br_mispred_reg;

  logic            res, taken, redirect;
  logic [XLEN-1:0] seq_pc, act_next, pred_next;

  // Resolution gated by rst so nothing strobes while reset is being sampled.
  always_comb begin
    seq_pc    = e_pc_reg + XLEN'(4);
    taken     = E_is_jump | E_cond_taken;
    res       = e_valid_reg & (E_is_cond | E_is_jump) & ~e_done_reg & ~rst;
    act_next  = taken ? E_jb_target : seq_pc;
    pred_next = (e_pred_taken_reg & e_btb_hit_reg) ? e_btb_target_reg : seq_pc;
    redirect  = res & (act_next != pred_next);
  end

  assign redirect_valid   = redirect;
  assign squash           = redirect;
  assign redirect_pc      = e_valid_reg ? act_next : '0;
  assign ex_update_en     = res;
  assign ex_actual_taken  = e_valid_reg & taken;
  assign ex_actual_target = e_valid_reg ? E_jb_target : '0;
  assign ex_pc            = e_pc_reg;
  assign pht_idx_ex       = e_pht_idx_reg;
  assign br_total         = br_total_reg;
  assign br_mispred       = br_mispred_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid_reg      <= 1'b0;
      d_pred_taken_reg <= 1'b0;
      d_btb_hit_reg    <= 1'b0;
      d_pc_reg         <= '0;
      d_btb_target_reg <= '0;
      d_pht_idx_reg    <= '0;
      e_valid_reg      <= 1'b0;
      e_pred_taken_reg <= 1'b0;
      e_btb_hit_reg    <= 1'b0;
      e_done_reg       <= 1'b0;
      e_pc_reg         <= '0;
      e_btb_target_reg <= '0;
      e_pht_idx_reg    <= '0;
      br_total_reg     <= '0;
      br_mispred_reg   <= '0;
    end else begin
      if (res)      br_total_reg   <= br_total_reg + CNT_W'(1);
      if (redirect) br_mispred_reg <= br_mispred_reg + CNT_W'(1);
      if (!stall) begin
        d_valid_reg      <= F_valid & ~redirect;
        d_pred_taken_reg <= F_pred_taken;
        d_btb_hit_reg    <= F_btb_hit;
        d_pc_reg         <= F_PC;
        d_btb_target_reg <= F_btb_target;
        d_pht_idx_reg    <= F_pht_idx;
        e_valid_reg      <= d_valid_reg & ~redirect;
        e_pred_taken_reg <= d_pred_taken_reg;
        e_btb_hit_reg    <= d_btb_hit_reg;
        e_pc_reg         <= d_pc_reg;
        e_btb_target_reg <= d_btb_target_reg;
        e_pht_idx_reg    <= d_pht_idx_reg;
        e_done_reg       <= 1'b0;
      end else begin
        // A held branch resolves once; the done flag blocks repeat strobes.
        if (redirect) d_valid_reg <= 1'b0;
        if (res)      e_done_reg  <= 1'b1;
      end
    end
  end

endmodule
